// File: rtl/dbg_bridge_pkg.sv
// Shared definitions for the serial debug bridge: opcodes, response codes,
// parser state encoding and the response payload handed to the tx sequencer.
package dbg_bridge_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 3;

   localparam logic [BYTE_W-1:0] OP_WRITE = 8'h01;
   localparam logic [BYTE_W-1:0] OP_READ  = 8'h02;
   localparam logic [BYTE_W-1:0] OP_LOCK  = 8'h03;

   localparam logic [BYTE_W-1:0] RSP_OK  = 8'hAA;
   localparam logic [BYTE_W-1:0] RSP_ERR = 8'hEE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_LOCK,
      S_BUS,
      S_RESP
   } state_t;

   // Response bytes left-aligned in word, cnt = number of bytes to send (1 or 4)
   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [CNT_W-1:0]  cnt;
   } resp_t;

   function automatic resp_t one_byte(input logic [BYTE_W-1:0] b);
      return '{word: {b, 24'h000000}, cnt: CNT_W'(1)};
   endfunction

   function automatic resp_t four_bytes(input logic [WORD_W-1:0] w);
      return '{word: w, cnt: CNT_W'(4)};
   endfunction

endpackage

// File: rtl/dbg_tx_seq.sv
// Response byte sequencer: shifts out up to four queued bytes MSB first,
// pacing each one behind tx_busy and keeping tx_stb pulses two cycles apart.
// Ports: clk/rst_n; load + resp (queue a response); tx_busy (from UART);
//        tx_data/tx_stb (to UART); busy_c (bytes still pending).
module dbg_tx_seq
   import dbg_bridge_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  resp_t             resp,
   input  logic              tx_busy,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_stb,
   output logic              busy_c
);

   logic [WORD_W-1:0] shreg;
   logic [CNT_W-1:0]  cnt;
   logic              fire_c;

   // The transmitter's busy only rises the cycle after tx_stb, so the strobe
   // cycle itself must also block the next send.
   assign fire_c = (cnt != '0) && !tx_busy && !tx_stb;
   assign busy_c = (cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         cnt     <= '0;
         tx_data <= '0;
         tx_stb  <= 1'b0;
      end else begin
         tx_stb <= fire_c;
         if (load) begin
            shreg <= resp.word;
            cnt   <= resp.cnt;
         end else if (fire_c) begin
            tx_data <= shreg[WORD_W-1 -: BYTE_W];
            shreg   <= {shreg[WORD_W-BYTE_W-1:0], 8'h00};
            cnt     <= cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/wb_dbg_bridge.sv
// Serial-command to Wishbone master bridge for the debug path. Parses
// write/read/lock commands from the UART receiver, runs one 32-bit Wishbone
// cycle per command and returns response bytes; owns the monitor write_lock.
// Ports: sys_clk/sys_rst_n; rx_data/rx_stb (UART rx); tx_data/tx_stb/tx_busy
//        (UART tx); wb_* (Wishbone master); write_lock (1 = locked).
module wb_dbg_bridge
   import dbg_bridge_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 1024,
   parameter int unsigned RX_TIMEOUT  = 1000000,
   parameter int unsigned TMO_W       = 20
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [BYTE_W-1:0] rx_data,
   input  logic              rx_stb,
   output logic [BYTE_W-1:0] tx_data,
   output logic              tx_stb,
   input  logic              tx_busy,
   output logic [WORD_W-1:0] wb_adr_o,
   output logic [WORD_W-1:0] wb_dat_o,
   input  logic [WORD_W-1:0] wb_dat_i,
   output logic [3:0]        wb_sel_o,
   output logic              wb_stb_o,
   output logic              wb_cyc_o,
   output logic              wb_we_o,
   input  logic              wb_ack_i,
   output logic              write_lock
);

   state_t            state, state_nx;
   logic              is_write, is_write_nx;
   logic [1:0]        bcnt, bcnt_nx;
   logic [WORD_W-1:0] addr, addr_nx;
   logic [TMO_W-1:0]  tmo, tmo_nx;
   logic [WORD_W-1:0] adr_nx, dat_nx;
   logic              cyc_nx, stb_nx, we_nx, lock_nx;
   logic              load_c;
   resp_t             resp_c;
   logic              tx_pend_c;

   assign wb_sel_o = 4'hF;

   // State and datapath registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= S_IDLE;
         is_write   <= 1'b0;
         bcnt       <= '0;
         addr       <= '0;
         tmo        <= '0;
         wb_adr_o   <= '0;
         wb_dat_o   <= '0;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_we_o    <= 1'b0;
         write_lock <= 1'b1;
      end else begin
         state      <= state_nx;
         is_write   <= is_write_nx;
         bcnt       <= bcnt_nx;
         addr       <= addr_nx;
         tmo        <= tmo_nx;
         wb_adr_o   <= adr_nx;
         wb_dat_o   <= dat_nx;
         wb_cyc_o   <= cyc_nx;
         wb_stb_o   <= stb_nx;
         wb_we_o    <= we_nx;
         write_lock <= lock_nx;
      end
   end

   // Command parser, bus sequencing and response queueing
   always_comb begin
      state_nx    = state;
      is_write_nx = is_write;
      bcnt_nx     = bcnt;
      addr_nx     = addr;
      tmo_nx      = tmo;
      adr_nx      = wb_adr_o;
      dat_nx      = wb_dat_o;
      cyc_nx      = wb_cyc_o;
      stb_nx      = wb_stb_o;
      we_nx       = wb_we_o;
      lock_nx     = write_lock;
      load_c      = 1'b0;
      resp_c      = '0;

      case (state)
         S_IDLE: begin
            tmo_nx = '0;
            if (rx_stb) begin
               bcnt_nx = '0;
               if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                  is_write_nx = (rx_data == OP_WRITE);
                  state_nx    = S_ADDR;
               end else if (rx_data == OP_LOCK) begin
                  state_nx = S_LOCK;
               end else begin
                  load_c   = 1'b1;
                  resp_c   = one_byte(RSP_ERR);
                  state_nx = S_RESP;
               end
            end
         end

         // Argument bytes share the inter-byte timeout
         S_ADDR, S_DATA, S_LOCK: begin
            if (rx_stb) begin
               tmo_nx  = '0;
               bcnt_nx = bcnt + 2'd1;
               if (state == S_ADDR) begin
                  addr_nx = {addr[23:0], rx_data};
                  if (bcnt == 2'd3) state_nx = is_write ? S_DATA : S_BUS;
               end else if (state == S_DATA) begin
                  dat_nx = {wb_dat_o[23:0], rx_data};
                  if (bcnt == 2'd3) state_nx = S_BUS;
               end else begin
                  lock_nx  = rx_data[0];
                  load_c   = 1'b1;
                  resp_c   = one_byte(RSP_OK);
                  state_nx = S_RESP;
               end
            end else if (tmo == TMO_W'(RX_TIMEOUT - 1)) begin
               state_nx = S_IDLE;
            end else begin
               tmo_nx = tmo + TMO_W'(1);
            end
         end

         // cyc low on entry: start the cycle; otherwise wait for ack or timeout.
         // Leaving for RESP the same edge cyc/stb drop keeps stb low after ack.
         S_BUS: begin
            if (!wb_cyc_o) begin
               cyc_nx = 1'b1;
               stb_nx = 1'b1;
               we_nx  = is_write;
               adr_nx = {addr[31:2], 2'b00};
               tmo_nx = '0;
            end else if (wb_ack_i) begin
               cyc_nx   = 1'b0;
               stb_nx   = 1'b0;
               we_nx    = 1'b0;
               load_c   = 1'b1;
               resp_c   = is_write ? one_byte(RSP_OK) : four_bytes(wb_dat_i);
               state_nx = S_RESP;
            end else if (tmo == TMO_W'(BUS_TIMEOUT - 1)) begin
               cyc_nx   = 1'b0;
               stb_nx   = 1'b0;
               we_nx    = 1'b0;
               load_c   = 1'b1;
               resp_c   = one_byte(RSP_ERR);
               state_nx = S_RESP;
            end else begin
               tmo_nx = tmo + TMO_W'(1);
            end
         end

         S_RESP: begin
            tmo_nx = '0;
            if (!tx_pend_c) state_nx = S_IDLE;
         end

         default: state_nx = S_IDLE;
      endcase
   end

   dbg_tx_seq u_tx_seq (
      .clk     (sys_clk),
      .rst_n   (sys_rst_n),
      .load    (load_c),
      .resp    (resp_c),
      .tx_busy (tx_busy),
      .tx_data (tx_data),
      .tx_stb  (tx_stb),
      .busy_c  (tx_pend_c)
   );

endmodule
